// File: rtl/ir_nec_pkg.sv
// NEC IR decoder shared types: FSM state enum, 2-bit state codes for the
// display stage, and default cycle-count thresholds for a 50 MHz clock.
package ir_nec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD_MARK,
        ST_LEAD_SPACE,
        ST_BIT_MARK,
        ST_BIT_SPACE,
        ST_DONE
    } fsm_t;

    localparam logic [1:0] CODE_IDLE   = 2'd0;
    localparam logic [1:0] CODE_LEADER = 2'd1;
    localparam logic [1:0] CODE_DATA   = 2'd2;
    localparam logic [1:0] CODE_DONE   = 2'd3;

    // Defaults in 50 MHz clock cycles.
    localparam int DEF_LEAD_MARK_MIN  = 400000;
    localparam int DEF_LEAD_SPACE_MIN = 200000;
    localparam int DEF_RPT_SPACE_MIN  = 90000;
    localparam int DEF_BIT_MARK_MIN   = 15000;
    localparam int DEF_BIT_MARK_MAX   = 45000;
    localparam int DEF_BIT_THRESH     = 56250;
    localparam int DEF_TIMEOUT        = 500000;
    localparam int DEF_CNT_W          = 20;

    function automatic logic [1:0] state_code(input fsm_t s);
        logic [1:0] c;
        c = CODE_IDLE;
        unique case (s)
            ST_IDLE:       c = CODE_IDLE;
            ST_LEAD_MARK,
            ST_LEAD_SPACE: c = CODE_LEADER;
            ST_BIT_MARK,
            ST_BIT_SPACE:  c = CODE_DATA;
            ST_DONE:       c = CODE_DONE;
            default:       c = CODE_IDLE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ir_input_sync.sv
// 2-FF synchronizer for the IR receiver line plus registered edge strobes.
// Ports: clk, rst (sync, active-high), ir_in (async) -> fall, rise strobes.
module ir_input_sync (
    input  logic clk,
    input  logic rst,
    input  logic ir_in,
    output logic fall,
    output logic rise
);

    logic s1;
    logic s2;
    logic prev;

    // Line idles high, so reset to 1 to avoid a spurious fall strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            prev <= 1'b1;
            fall <= 1'b0;
            rise <= 1'b0;
        end else begin
            s1   <= ir_in;
            s2   <= s1;
            prev <= s2;
            fall <= prev & ~s2;
            rise <= ~prev & s2;
        end
    end

endmodule

// File: rtl/nec_ir_decoder.sv
// NEC IR frame decoder: measures mark/space widths, decodes leader, 32 data
// bits LSB-first and repeat codes, and presents eight nibbles plus a state
// code to the LCD display stage.
// Ports: clk, rst (sync, active-high), ir_in (active-low) in;
//        state[1:0], data7..data0[3:0], frame_valid, repeat_pulse,
//        frame_err out.
// Build option: define NEC_CHECKSUM_EN to reject frames with KI != ~K.
module nec_ir_decoder
    import ir_nec_pkg::*;
#(
    parameter int LEAD_MARK_MIN  = DEF_LEAD_MARK_MIN,
    parameter int LEAD_SPACE_MIN = DEF_LEAD_SPACE_MIN,
    parameter int RPT_SPACE_MIN  = DEF_RPT_SPACE_MIN,
    parameter int BIT_MARK_MIN   = DEF_BIT_MARK_MIN,
    parameter int BIT_MARK_MAX   = DEF_BIT_MARK_MAX,
    parameter int BIT_THRESH     = DEF_BIT_THRESH,
    parameter int TIMEOUT        = DEF_TIMEOUT,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ir_in,
    output logic [1:0] state,
    output logic [3:0] data7,
    output logic [3:0] data6,
    output logic [3:0] data5,
    output logic [3:0] data4,
    output logic [3:0] data3,
    output logic [3:0] data2,
    output logic [3:0] data1,
    output logic [3:0] data0,
    output logic       frame_valid,
    output logic       repeat_pulse,
    output logic       frame_err
);

    localparam logic [CNT_W-1:0] LMM = CNT_W'(LEAD_MARK_MIN);
    localparam logic [CNT_W-1:0] LSM = CNT_W'(LEAD_SPACE_MIN);
    localparam logic [CNT_W-1:0] RSM = CNT_W'(RPT_SPACE_MIN);
    localparam logic [CNT_W-1:0] BMN = CNT_W'(BIT_MARK_MIN);
    localparam logic [CNT_W-1:0] BMX = CNT_W'(BIT_MARK_MAX);
    localparam logic [CNT_W-1:0] THR = CNT_W'(BIT_THRESH);
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    logic             fall;
    logic             rise;
    logic [CNT_W-1:0] cnt;
    fsm_t             st;
    fsm_t             st_nxt;
    logic [4:0]       idx;
    logic [4:0]       idx_nxt;
    logic [31:0]      shf;
    logic [31:0]      shf_nxt;
    logic [31:0]      dat;
    logic [31:0]      dat_nxt;
    logic             have;
    logic             have_nxt;
    logic             fv_nxt;
    logic             rp_nxt;
    logic             err_nxt;
    logic             tmo;
    logic             bitv;
    logic             csum_ok;

    ir_input_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .ir_in (ir_in),
        .fall  (fall),
        .rise  (rise)
    );

    // Width counter: cycles since the last edge, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (fall || rise) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // An edge in the same cycle takes priority over the timeout.
    assign tmo  = (cnt == TMO) && !fall && !rise;
    assign bitv = (cnt >= THR);

    always_comb begin
        st_nxt   = st;
        idx_nxt  = idx;
        shf_nxt  = shf;
        dat_nxt  = dat;
        have_nxt = have;
        fv_nxt   = 1'b0;
        rp_nxt   = 1'b0;
        err_nxt  = 1'b0;
        csum_ok  = 1'b1;
        unique case (st)
            ST_IDLE: begin
                if (fall) st_nxt = ST_LEAD_MARK;
            end
            ST_LEAD_MARK: begin
                if (rise) begin
                    if (cnt >= LMM) begin
                        st_nxt = ST_LEAD_SPACE;
                    end else begin
                        st_nxt  = ST_IDLE;
                        err_nxt = 1'b1;
                    end
                end else if (tmo) begin
                    st_nxt  = ST_IDLE;
                    err_nxt = 1'b1;
                end
            end
            ST_LEAD_SPACE: begin
                if (fall) begin
                    if (cnt >= LSM) begin
                        st_nxt  = ST_BIT_MARK;
                        idx_nxt = 5'd0;
                    end else if (cnt >= RSM && have) begin
                        st_nxt = ST_DONE;
                        rp_nxt = 1'b1;
                    end else begin
                        st_nxt  = ST_IDLE;
                        err_nxt = 1'b1;
                    end
                end else if (tmo) begin
                    st_nxt  = ST_IDLE;
                    err_nxt = 1'b1;
                end
            end
            ST_BIT_MARK: begin
                if (rise) begin
                    if (cnt >= BMN && cnt <= BMX) begin
                        st_nxt = ST_BIT_SPACE;
                    end else begin
                        st_nxt  = ST_IDLE;
                        err_nxt = 1'b1;
                    end
                end else if (tmo) begin
                    st_nxt  = ST_IDLE;
                    err_nxt = 1'b1;
                end
            end
            ST_BIT_SPACE: begin
                if (fall) begin
                    shf_nxt[idx] = bitv;
                    if (idx == 5'd31) begin
`ifdef NEC_CHECKSUM_EN
                        csum_ok = (shf_nxt[31:24] == ~shf_nxt[23:16]);
`else
                        csum_ok = 1'b1;
`endif
                        if (csum_ok) begin
                            // Nibble order C0,C1,K,KI from data7 down.
                            dat_nxt  = {shf_nxt[7:0], shf_nxt[15:8],
                                        shf_nxt[23:16], shf_nxt[31:24]};
                            have_nxt = 1'b1;
                            fv_nxt   = 1'b1;
                            st_nxt   = ST_DONE;
                        end else begin
                            err_nxt = 1'b1;
                            st_nxt  = ST_IDLE;
                        end
                    end else begin
                        idx_nxt = idx + 5'd1;
                        st_nxt  = ST_BIT_MARK;
                    end
                end else if (tmo) begin
                    st_nxt  = ST_IDLE;
                    err_nxt = 1'b1;
                end
            end
            ST_DONE: begin
                // Stop-burst rise is ignored; next fall starts a frame.
                if (fall) st_nxt = ST_LEAD_MARK;
            end
            default: begin
                st_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st           <= ST_IDLE;
            idx          <= 5'd0;
            shf          <= '0;
            dat          <= '0;
            have         <= 1'b0;
            frame_valid  <= 1'b0;
            repeat_pulse <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            st           <= st_nxt;
            idx          <= idx_nxt;
            shf          <= shf_nxt;
            dat          <= dat_nxt;
            have         <= have_nxt;
            frame_valid  <= fv_nxt;
            repeat_pulse <= rp_nxt;
            frame_err    <= err_nxt;
        end
    end

    assign state = state_code(st);
    assign {data7, data6, data5, data4,
            data3, data2, data1, data0} = dat;

endmodule
